// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative multiply/divide sequencer for the EX stage.
// Runs MULT/MULTU/DIV/DIVU over a fixed schedule and owns the HI/LO registers:
// one accept cycle, WIDTH shift-add / restoring-subtract cycles, then one
// sign-correction cycle that writes HI/LO. Also services MTHI/MTLO.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, op       request (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   rs_val, rt_val  multiplicand/dividend, multiplier/divisor
//   flush           squash the in-flight operation
//   mthi, mtlo      write wdata to HI / LO (idle only, start wins)
//   hi, lo          architectural HI/LO
//   busy            stall request (combinational)
//   done            one-cycle pulse after HI/LO take an operation result
module muldiv_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             flush,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t               state_reg, state_next;
   logic                 accept;

   logic                 op_div_reg;
   logic                 neg_q_reg;   // product / quotient negative
   logic                 neg_r_reg;   // remainder negative
   logic                 div_zero_reg;
   logic [WIDTH-1:0]     a_reg;       // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0]   acc_reg;     // {HI part, LO part} working register
   logic [WIDTH-1:0]     rs_raw_reg;  // raw dividend, returned on divide by zero
   logic [CNT_W-1:0]     cnt_reg;
   logic [WIDTH-1:0]     hi_reg, lo_reg;
   logic                 done_reg;

   // Operand magnitudes: signed ops (op[0]==0) take absolute values.
   logic                 rs_neg, rt_neg;
   logic [WIDTH-1:0]     rs_mag, rt_mag;

   assign rs_neg = ~op[0] & rs_val[WIDTH-1];
   assign rt_neg = ~op[0] & rt_val[WIDTH-1];
   assign rs_mag = rs_neg ? (~rs_val + WIDTH'(1)) : rs_val;
   assign rt_mag = rt_neg ? (~rt_val + WIDTH'(1)) : rt_val;

   assign accept = (state_reg == IDLE) & start & ~flush;

   // Multiply step: conditionally add multiplicand to the upper half, then
   // shift the whole accumulator right, keeping the carry as the new MSB.
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_step;

   assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, a_reg} : '0);
   assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

   // Restoring divide step: shift the next dividend bit into the partial
   // remainder; keep the difference when it did not borrow.
   // The partial remainder is always below 2*divisor, so bit WIDTH of the
   // difference is a valid sign.
   logic [WIDTH:0]       div_rem_sh;
   logic [WIDTH:0]       div_diff;
   logic                 div_ge;
   logic [2*WIDTH-1:0]   div_step;

   assign div_rem_sh = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
   assign div_diff   = div_rem_sh - {1'b0, a_reg};
   assign div_ge     = ~div_diff[WIDTH];
   assign div_step   = {(div_ge ? div_diff[WIDTH-1:0] : div_rem_sh[WIDTH-1:0]),
                        acc_reg[WIDTH-2:0], div_ge};

   // Sign correction.
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo_raw, rem_raw, quo_fix, rem_fix;

   assign prod_fix = neg_q_reg ? (~acc_reg + (2*WIDTH)'(1)) : acc_reg;
   assign quo_raw  = acc_reg[WIDTH-1:0];
   assign rem_raw  = acc_reg[2*WIDTH-1:WIDTH];
   assign quo_fix  = neg_q_reg ? (~quo_raw + WIDTH'(1)) : quo_raw;
   assign rem_fix  = neg_r_reg ? (~rem_raw + WIDTH'(1)) : rem_raw;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = CALC;
         CALC:    if (flush) state_next = IDLE;
                  else if (cnt_reg == LAST_CNT) state_next = SIGN;
         SIGN:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      busy = (state_reg != IDLE) | accept;
   end

   assign hi   = hi_reg;
   assign lo   = lo_reg;
   assign done = done_reg;

   // Datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         op_div_reg   <= 1'b0;
         neg_q_reg    <= 1'b0;
         neg_r_reg    <= 1'b0;
         div_zero_reg <= 1'b0;
         a_reg        <= '0;
         acc_reg      <= '0;
         rs_raw_reg   <= '0;
         cnt_reg      <= '0;
         hi_reg       <= '0;
         lo_reg       <= '0;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  op_div_reg   <= op[1];
                  neg_q_reg    <= rs_neg ^ rt_neg;
                  neg_r_reg    <= rs_neg;
                  div_zero_reg <= op[1] & (rt_val == '0);
                  a_reg        <= rt_mag;
                  acc_reg      <= {{WIDTH{1'b0}}, rs_mag};
                  rs_raw_reg   <= rs_val;
                  cnt_reg      <= '0;
               end else begin
                  if (mthi) hi_reg <= wdata;
                  if (mtlo) lo_reg <= wdata;
               end
            end
            CALC: begin
               if (!flush) begin
                  acc_reg <= op_div_reg ? div_step : mul_step;
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            SIGN: begin
               if (!flush) begin
                  done_reg <= 1'b1;
                  if (!op_div_reg) begin
                     hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                     lo_reg <= prod_fix[WIDTH-1:0];
                  end else if (div_zero_reg) begin
                     hi_reg <= rs_raw_reg;
                     lo_reg <= '1;
                  end else begin
                     hi_reg <= rem_fix;
                     lo_reg <= quo_fix;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: directed scenarios plus randomized operations
// checked against an arithmetic reference model.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] rs_val = '0;
   logic [31:0] rt_val = '0;
   logic        flush = 1'b0;
   logic        mthi = 1'b0;
   logic        mtlo = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] hi, lo;
   logic        busy, done;

   int total = 0;
   int bad = 0;

   muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
      .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Reference model: plain 64-bit arithmetic.
   function automatic void model(input logic [1:0] o, input logic [31:0] a, b,
                                 output logic [31:0] eh, output logic [31:0] el);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      eh = '0;
      el = '0;
      case (o)
         2'd0: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
         2'd1: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
         default: begin
            if (b == 32'd0) begin
               eh = a;
               el = 32'hFFFF_FFFF;
            end else if (o == 2'd2) begin
               q = sa / sb;
               r = sa % sb;
               eh = r[31:0];
               el = q[31:0];
            end else begin
               eh = a % b;
               el = a / b;
            end
         end
      endcase
   endfunction

   // Drives one request in the current cycle (cycle 0) and follows it until
   // busy drops. Reports busy cycle count, cycle of the done pulse (-1 none),
   // HI/LO seen at done, and HI at cycle 1. fl_cyc >= 0 asserts flush then.
   task automatic issue_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           input int fl_cyc, output int bcyc, output int dcyc,
                           output logic [31:0] h, output logic [31:0] l,
                           output logic [31:0] hm);
      bit fin;
      op = o; rs_val = a; rt_val = b; start = 1'b1;
      #1;
      bcyc = busy ? 1 : 0;
      dcyc = -1;
      h = hi; l = lo; hm = hi;
      fin = 1'b0;
      for (int c = 1; c <= 60 && !fin; c++) begin
         @(negedge clk);
         start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
         flush = (c == fl_cyc);
         #1;
         if (c == 1) hm = hi;
         if (busy) bcyc++;
         if (done && dcyc < 0) begin dcyc = c; h = hi; l = lo; end
         if (!busy) begin flush = 1'b0; fin = 1'b1; end
      end
      flush = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b1; op = 2'd1; rs_val = 32'd9; rt_val = 32'd9;
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
      repeat (3) @(negedge clk);
      rst = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      #1;
      total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'd0); end
      total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'd0); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      $display("reset: hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
   endtask

   task automatic test_multu_max();
      int bc, dc; logic [31:0] h, l, hm;
      @(negedge clk);
      issue_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, bc, dc, h, l, hm);
      total++; if (bc !== 34) begin bad++; $display("FAIL multu_busy_cycles got=%0d exp=34", bc); end
      total++; if (dc !== 34) begin bad++; $display("FAIL multu_done_cycle got=%0d exp=34", dc); end
      total++; if (h !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got=%h exp=fffffffe", h); end
      total++; if (l !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo got=%h exp=00000001", l); end
      @(negedge clk); #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL multu_done_width got=%b exp=0", done); end
      $display("MULTU ffffffff*ffffffff: busy=%0d done@%0d hi=%h lo=%h", bc, dc, h, l);
   endtask

   task automatic test_back_to_back();
      int bc, dc; logic [31:0] h, l, hm;
      @(negedge clk);
      issue_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, -1, bc, dc, h, l, hm);
      total++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB) begin
         bad++; $display("FAIL mult_neg got=%h_%h exp=ffffffff_ffffffeb", h, l); end
      $display("MULT -3*7: busy=%0d done@%0d hi=%h lo=%h", bc, dc, h, l);
      // Still in the cycle where busy dropped: issue the next one right away.
      issue_op(2'd0, 32'h0001_0000, 32'h0001_0000, -1, bc, dc, h, l, hm);
      total++; if (bc !== 34 || dc !== 34) begin
         bad++; $display("FAIL b2b_timing got=busy%0d/done%0d exp=34/34", bc, dc); end
      total++; if (h !== 32'h1 || l !== 32'h0) begin
         bad++; $display("FAIL b2b_result got=%h_%h exp=00000001_00000000", h, l); end
      $display("MULT b2b 10000*10000: busy=%0d done@%0d hi=%h lo=%h", bc, dc, h, l);
   endtask

   task automatic test_div();
      int bc, dc; logic [31:0] h, l, hm;
      logic [1:0]  ops [4] = '{2'd2, 2'd3, 2'd2, 2'd3};
      logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd5};
      logic [31:0] bs  [4] = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0};
      logic [31:0] ehs [4] = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd5};
      logic [31:0] els [4] = '{32'hFFFF_FFFD, 32'd14, 32'h8000_0000, 32'hFFFF_FFFF};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         issue_op(ops[i], as[i], bs[i], -1, bc, dc, h, l, hm);
         total++; if (h !== ehs[i] || l !== els[i] || dc !== 34) begin
            bad++; $display("FAIL div_case%0d got=%h_%h@%0d exp=%h_%h@34", i, h, l, dc, ehs[i], els[i]); end
         $display("DIV op=%0d %h/%h: done@%0d hi=%h lo=%h", ops[i], as[i], bs[i], dc, h, l);
      end
   endtask

   task automatic test_mthi_mtlo_flush();
      int bc, dc; logic [31:0] h, l, hm;
      @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_0009;
      @(negedge clk); mthi = 1'b0; mtlo = 1'b0; #1;
      total++; if (hi !== 32'h9 || lo !== 32'h9) begin
         bad++; $display("FAIL mthi_mtlo_both got=%h_%h exp=00000009_00000009", hi, lo); end
      mthi = 1'b1; wdata = 32'h1234;
      @(negedge clk); mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5678;
      @(negedge clk); mtlo = 1'b0; #1;
      total++; if (hi !== 32'h1234 || lo !== 32'h5678) begin
         bad++; $display("FAIL mthi_mtlo got=%h_%h exp=00001234_00005678", hi, lo); end
      $display("mthi/mtlo: hi=%h lo=%h", hi, lo);
      // start together with flush in idle is refused
      @(negedge clk); start = 1'b1; flush = 1'b1; op = 2'd1; rs_val = 32'd2; rt_val = 32'd3; #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_flush_busy got=%b exp=0", busy); end
      @(negedge clk); start = 1'b0; flush = 1'b0; #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_flush_accept got=%b exp=0", busy); end
      issue_op(2'd0, 32'd3, 32'd4, 10, bc, dc, h, l, hm);
      total++; if (bc !== 11 || dc !== -1) begin
         bad++; $display("FAIL flush_timing got=busy%0d/done%0d exp=11/-1", bc, dc); end
      total++; if (hi !== 32'h1234 || lo !== 32'h5678) begin
         bad++; $display("FAIL flush_hilo got=%h_%h exp=00001234_00005678", hi, lo); end
      @(negedge clk); #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL flush_done got=%b exp=0", done); end
      $display("MULT 3*4 flushed@10: busy=%0d hi=%h lo=%h", bc, hi, lo);
   endtask

   task automatic test_coincident();
      int bc, dc; logic [31:0] h, l, hm;
      bit fin;
      // start + mthi: op wins
      @(negedge clk); mthi = 1'b1; wdata = 32'h0000_AAAA;
      issue_op(2'd1, 32'd6, 32'd7, -1, bc, dc, h, l, hm);
      total++; if (hm !== 32'h1234) begin bad++; $display("FAIL start_mthi_ignored got=%h exp=00001234", hm); end
      total++; if (h !== 32'd0 || l !== 32'd42) begin
         bad++; $display("FAIL start_mthi_result got=%h_%h exp=00000000_0000002a", h, l); end
      $display("start+mthi: hi@1=%h result hi=%h lo=%h", hm, h, l);
      // mtlo during CALC is ignored
      @(negedge clk); op = 2'd3; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
      fin = 1'b0;
      for (int c = 1; c <= 60 && !fin; c++) begin
         @(negedge clk);
         start = 1'b0; mtlo = (c == 5); wdata = 32'h5555;
         #1;
         if (c == 6) begin
            total++; if (lo !== 32'd42) begin bad++; $display("FAIL mtlo_calc got=%h exp=0000002a", lo); end
         end
         if (!busy) fin = 1'b1;
      end
      mtlo = 1'b0;
      total++; if (hi !== 32'd2 || lo !== 32'd14) begin
         bad++; $display("FAIL mtlo_calc_result got=%h_%h exp=00000002_0000000e", hi, lo); end
      $display("mtlo in CALC: hi=%h lo=%h", hi, lo);
      // reset in cycle 20 of a DIV
      @(negedge clk); op = 2'd2; rs_val = 32'hFFFF_FFF9; rt_val = 32'd2; start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk); start = 1'b0; rst = (c == 20);
      end
      @(negedge clk); rst = 1'b0; #1;
      total++; if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL rst_mid_div got=%h_%h busy=%b done=%b exp=0_0 0 0", hi, lo, busy, done); end
      $display("rst mid-DIV: hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
   endtask

   task automatic test_random();
      int bc, dc; logic [31:0] h, l, hm, a, b, eh, el;
      logic [1:0] o;
      for (int i = 0; i < 24; i++) begin
         o = 2'($urandom_range(0, 3));
         a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         model(o, a, b, eh, el);
         @(negedge clk);
         issue_op(o, a, b, -1, bc, dc, h, l, hm);
         total++; if (h !== eh || l !== el || bc !== 34 || dc !== 34) begin
            bad++; $display("FAIL random%0d op=%0d %h,%h got=%h_%h busy%0d done%0d exp=%h_%h 34 34",
                            i, o, a, b, h, l, bc, dc, eh, el); end
         $display("rand op=%0d %h,%h: hi=%h lo=%h", o, a, b, h, l);
      end
   endtask

   initial begin
      test_reset();
      test_multu_max();
      test_back_to_back();
      test_div();
      test_mthi_mtlo_flush();
      test_coincident();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
